omsp_hmac_msg_port: RTL and testbench
=====================================

Name: omsp_hmac_msg_port

Overview:
Message-side responder for the HMAC control FSM's word protocol (start_continue / data_available / data_is_long / busy).
- Absorbs 16-bit or 8-bit message chunks, packs them big-endian into 32-bit words, and frames 512-bit blocks for the SHA-256 compression core.
- On finalize, appends SHA padding and the 64-bit bit-length.
- Serves the 256-bit digest back as 16 sequential 16-bit words.
- Sits between the control FSM and the hash core; key mixing is done by the core.

Parameters:
LEN_W, 16, width of the message byte counter; bit length = {byte_cnt, 3'b000}, upper length bits zero.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
hmac_reset  in  1  synchronous soft clear, same effect as reset
start_continue  in  1  one-cycle request strobe from control
data_available  in  1  qualifies start_continue: 1 = absorb data_in, 0 = finalize/advance output
data_is_long  in  1  1 = absorb data_in[15:8] then data_in[7:0]; 0 = absorb data_in[7:0] only
data_in  in  16  message data, sampled on the start_continue cycle
busy  out  1  request in progress
data_out  out  16  current digest halfword
core_wr  out  1  write core_wdata into core message word core_addr
core_addr  out  4  message word index within block
core_wdata  out  32  big-endian packed message word
core_start  out  1  one-cycle pulse: compress current block
core_busy  in  1  compression in progress
core_digest_sel  out  3  digest word select
core_digest  in  32  selected digest word

Behaviour:
- Reset or hmac_reset:
  - state IDLE; byte_cnt=0; word accumulator=0; out_idx=0; finalized=0.
  - core_wr=0, core_start=0, core_addr=0, core_wdata=0.
  - hmac_reset does not abort a compression already running in the core.
- busy = start_continue | (state != IDLE), combinational. This is required: control samples busy in the same cycle start_continue is high.
- States: IDLE, ABSORB_HI, ABSORB_LO, BLK_WAIT, PAD, LEN, FIN_WAIT.
- IDLE + start_continue + data_available + !finalized:
  - latch data_in and data_is_long.
  - go to ABSORB_HI if long, else ABSORB_LO.
- ABSORB_HI / ABSORB_LO: one byte per cycle.
  - Byte shifts into the accumulator; byte_cnt increments.
  - When byte_cnt[1:0] wraps to 0, pulse core_wr with core_addr=byte_cnt[5:2] of the completed word.
  - When byte_cnt[5:0] wraps to 0, pulse core_start in the cycle after that core_wr, then go to BLK_WAIT; otherwise go to IDLE.
- BLK_WAIT: stay while core_busy is high (also wait one cycle for core_busy to rise), then return to the pending absorb/pad state or IDLE.
- IDLE + start_continue + !data_available + !finalized: go to PAD.
  - Emit byte 0x80, then 0x00 until byte_cnt[5:0]==56, then go to LEN.
  - If 0x80 lands at index >=56, zero-fill to 64, compress, then zero-fill the next block to 56.
  - Pad bytes do not increment the length used in LEN; the message length is frozen when padding starts.
- LEN: emit 8 length bytes, MSB first, then core_start, then FIN_WAIT.
- FIN_WAIT: wait for core_busy low; set finalized=1, out_idx=0, go to IDLE.
- Output phase:
  - core_digest_sel = out_idx[3:1].
  - data_out = out_idx[0] ? core_digest[15:0] : core_digest[31:16].
  - start_continue + !data_available + finalized: out_idx increments, saturating at 15; busy high one cycle only.
  - start_continue + data_available while finalized: ignored, busy one cycle.
- start_continue while state != IDLE: ignored; control must not issue it.
- byte_cnt overflow wraps silently.

Test Plan:
- Long 0x6162 then short 0x63, finalize:
  - core_wr word0=0x61626380, words1-14=0, word15=0x00000018.
  - Exactly one core_start.
  - busy low within 40 cycles after core_busy drops.
- 28 long words of 0x0000 (56 bytes), finalize:
  - Block 1 word14=0x80000000.
  - Two core_starts.
  - Block 2 words0-13=0, word14=0, word15=0x000001C0.
- start_continue + data_available=1 in cycle N: busy=1 in cycle N combinationally; cycle N+1 busy=1; short write returns busy=0 by N+3.
- After finalize with core_digest words 0..7 = 0x00010002, 0x00030004, ...: 16 advance pulses yield data_out 0x0001..0x0010; further pulses hold at 0x0010.
- hmac_reset mid-block after 5 bytes, then "abc" + finalize: same core_wdata as the first scenario (byte_cnt restarted at 0).
- Assert reset while in PAD: all outputs 0, state IDLE next cycle, no core_start afterwards.

Source files
------------

// File: rtl/omsp_hmac_msg_port.sv
// Message-side responder for the HMAC control FSM: packs bytes into big-endian words, frames and pads
// SHA-256 blocks, and serves the digest back as halfwords. One byte per cycle; busy holds off control.
module omsp_hmac_msg_port #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hmac_reset,
  input  logic        start_continue,
  input  logic        data_available,
  input  logic        data_is_long,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        core_wr,
  output logic [3:0]  core_addr,
  output logic [31:0] core_wdata,
  output logic        core_start,
  input  logic        core_busy,
  output logic [2:0]  core_digest_sel,
  input  logic [31:0] core_digest
);

  typedef enum logic [2:0] {
    IDLE, ABSORB_HI, ABSORB_LO, BLK_WAIT, PAD, LEN, FIN_WAIT
  } state_t;

  state_t            state_q, ret_q;
  logic [LEN_W-1:0]  byte_cnt_q, msg_len_q, cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic [15:0]       data_q;
  logic [3:0]        out_idx_q;
  logic              finalized_q, pad_first_q;
  logic [2:0]        len_idx_q;
  logic [1:0]        ph_q;
  logic              core_wr_q, core_start_q;
  logic [3:0]        core_addr_q;
  logic [31:0]       core_wdata_q;
  logic [63:0]       len_bits;
  logic [7:0]        emit_byte;
  logic              emit, word_done, blk_done;

  // Bit length is frozen at the start of padding; only the byte count is carried, upper bits zero.
  assign len_bits = {{(61-LEN_W){1'b0}}, msg_len_q, 3'b000};

  always_comb begin
    emit_byte = 8'h00;
    emit      = 1'b0;
    case (state_q)
      ABSORB_HI: begin emit = 1'b1; emit_byte = data_q[15:8]; end
      ABSORB_LO: begin emit = 1'b1; emit_byte = data_q[7:0]; end
      PAD:       begin emit = 1'b1; emit_byte = pad_first_q ? 8'h80 : 8'h00; end
      LEN:       begin emit = 1'b1; emit_byte = len_bits[{~len_idx_q, 3'b000} +: 8]; end
      default:   begin emit = 1'b0; emit_byte = 8'h00; end
    endcase
    acc_d     = {acc_q[23:0], emit_byte};
    cnt_d     = byte_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
    word_done = (cnt_d[1:0] == 2'd0);
    blk_done  = (cnt_d[5:0] == 6'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; ret_q <= IDLE; byte_cnt_q <= '0; msg_len_q <= '0;
      acc_q <= '0; data_q <= '0; out_idx_q <= '0; finalized_q <= 1'b0;
      pad_first_q <= 1'b0; len_idx_q <= '0; ph_q <= '0;
      core_wr_q <= 1'b0; core_start_q <= 1'b0; core_addr_q <= '0; core_wdata_q <= '0;
    end else if (hmac_reset) begin
      state_q <= IDLE; ret_q <= IDLE; byte_cnt_q <= '0; msg_len_q <= '0;
      acc_q <= '0; data_q <= '0; out_idx_q <= '0; finalized_q <= 1'b0;
      pad_first_q <= 1'b0; len_idx_q <= '0; ph_q <= '0;
      core_wr_q <= 1'b0; core_start_q <= 1'b0; core_addr_q <= '0; core_wdata_q <= '0;
    end else begin
      core_wr_q    <= 1'b0;
      core_start_q <= 1'b0;
      if (emit) begin
        acc_q      <= acc_d;
        byte_cnt_q <= cnt_d;
        if (word_done) begin
          core_wr_q    <= 1'b1;
          core_addr_q  <= byte_cnt_q[5:2];
          core_wdata_q <= acc_d;
        end
      end
      case (state_q)
        IDLE: begin
          if (start_continue) begin
            if (!finalized_q && data_available) begin
              data_q  <= data_in;
              state_q <= data_is_long ? ABSORB_HI : ABSORB_LO;
            end else if (!finalized_q) begin
              state_q     <= PAD;
              msg_len_q   <= byte_cnt_q;
              pad_first_q <= 1'b1;
            end else if (!data_available && out_idx_q != 4'd15) begin
              out_idx_q <= out_idx_q + 4'd1;
            end
          end
        end
        ABSORB_HI: begin
          if (blk_done) begin
            state_q <= BLK_WAIT; ret_q <= ABSORB_LO; ph_q <= 2'd0;
          end else begin
            state_q <= ABSORB_LO;
          end
        end
        ABSORB_LO: begin
          if (blk_done) begin
            state_q <= BLK_WAIT; ret_q <= IDLE; ph_q <= 2'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        PAD: begin
          pad_first_q <= 1'b0;
          if (blk_done) begin
            state_q <= BLK_WAIT; ret_q <= PAD; ph_q <= 2'd0;
          end else if (cnt_d[5:0] == 6'd56) begin
            state_q <= LEN; len_idx_q <= 3'd0;
          end
        end
        LEN: begin
          len_idx_q <= len_idx_q + 3'd1;
          if (blk_done) begin
            state_q <= FIN_WAIT; ph_q <= 2'd0;
          end
        end
        BLK_WAIT, FIN_WAIT: begin
          // Start follows the final word write by one cycle, then allow a cycle for core_busy to rise.
          case (ph_q)
            2'd0:    begin core_start_q <= 1'b1; ph_q <= 2'd1; end
            2'd1:    ph_q <= 2'd2;
            default: begin
              if (!core_busy) begin
                if (state_q == FIN_WAIT) begin
                  state_q     <= IDLE;
                  finalized_q <= 1'b1;
                  out_idx_q   <= 4'd0;
                end else begin
                  state_q <= ret_q;
                end
              end
            end
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = start_continue | (state_q != IDLE);
  assign core_wr         = core_wr_q;
  assign core_addr       = core_addr_q;
  assign core_wdata      = core_wdata_q;
  assign core_start      = core_start_q;
  assign core_digest_sel = out_idx_q[3:1];
  assign data_out        = out_idx_q[0] ? core_digest[15:0] : core_digest[31:16];

endmodule

// File: tb/tb_omsp_hmac_msg_port.sv
// Scoreboard bench for omsp_hmac_msg_port with a small behavioural compression-core stand-in.
module tb_omsp_hmac_msg_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hmac_reset = 1'b0;
  logic        start_continue = 1'b0;
  logic        data_available = 1'b0;
  logic        data_is_long = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        busy;
  logic [15:0] data_out;
  logic        core_wr;
  logic [3:0]  core_addr;
  logic [31:0] core_wdata;
  logic        core_start;
  logic        core_busy;
  logic [2:0]  core_digest_sel;
  logic [31:0] core_digest;

  int n_checks = 0;
  int n_fail   = 0;
  int starts   = 0;
  int cb_cnt   = 0;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t e;

  logic [15:0] dig_hi, dig_lo;

  omsp_hmac_msg_port #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .hmac_reset(hmac_reset),
    .start_continue(start_continue), .data_available(data_available),
    .data_is_long(data_is_long), .data_in(data_in), .busy(busy), .data_out(data_out),
    .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_start(core_start), .core_busy(core_busy),
    .core_digest_sel(core_digest_sel), .core_digest(core_digest)
  );

  always #5 clk = ~clk;

  // Core stand-in: busy for 10 cycles starting the cycle after start; digest word n = {2n+1, 2n+2}.
  always @(posedge clk or posedge reset) begin
    if (reset) cb_cnt <= 0;
    else if (core_start) cb_cnt <= 10;
    else if (cb_cnt > 0) cb_cnt <= cb_cnt - 1;
  end
  assign core_busy   = (cb_cnt != 0);
  assign dig_hi      = {12'd0, core_digest_sel, 1'b0} + 16'd1;
  assign dig_lo      = {12'd0, core_digest_sel, 1'b0} + 16'd2;
  assign core_digest = {dig_hi, dig_lo};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic push_w(input int a, input logic [31:0] d);
    wr_t w;
    w.a = 4'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every core write is matched against the head of the expected-write queue.
  always @(negedge clk) begin
    if (core_start) starts++;
    if (core_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected core_wr: addr %0d data 0x%h, expected none", core_addr, core_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("core_addr", {28'd0, core_addr}, {28'd0, e.a});
        chk("core_wdata", core_wdata, e.d);
      end
    end
  end

  task automatic wait_idle(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      #1;
      if (!busy) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL busy timeout: still busy after %0d cycles, expected idle", lim);
    end
  endtask

  task automatic req(input logic da, input logic lng, input logic [15:0] d);
    @(negedge clk);
    start_continue = 1'b1; data_available = da; data_is_long = lng; data_in = d;
    @(negedge clk);
    start_continue = 1'b0; data_available = 1'b0; data_is_long = 1'b0;
    wait_idle(600);
  endtask

  task automatic pulse_hmac_reset();
    @(negedge clk); hmac_reset = 1'b1;
    @(negedge clk); hmac_reset = 1'b0;
  endtask

  // Finalize and check compression count plus release of busy after the core goes idle.
  task automatic finalize(input int n_starts);
    int s0 = starts;
    int i;
    @(negedge clk);
    start_continue = 1'b1; data_available = 1'b0;
    @(negedge clk);
    start_continue = 1'b0;
    for (i = 0; i < 800; i++) begin
      #1;
      if (starts >= s0 + n_starts) break;
      @(negedge clk);
    end
    chk("core_start count reached", starts - s0, n_starts);
    @(negedge clk); @(negedge clk);
    for (i = 0; i < 50; i++) begin
      #1;
      if (!core_busy) break;
      @(negedge clk);
    end
    for (i = 0; i < 40; i++) begin
      #1;
      if (!busy) break;
      @(negedge clk);
    end
    chk("busy low within 40 cycles of core idle", busy, 0);
    repeat (20) @(negedge clk);
    #1 chk("no extra core_start", starts - s0, n_starts);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    #23 reset = 1'b0;
    @(negedge clk); #1;
    chk("reset busy", busy, 0);
    chk("reset core_wr", core_wr, 0);
    chk("reset core_start", core_start, 0);
    chk("reset core_addr", core_addr, 0);
    chk("reset core_wdata", core_wdata, 0);
    chk("reset digest_sel", core_digest_sel, 0);
    chk("reset data_out", data_out, 16'h0001);

    // Five bytes then soft clear; the first four form word 0.
    push_w(0, 32'h11223344);
    req(1, 1, 16'h1122);
    req(1, 1, 16'h3344);
    @(negedge clk);
    start_continue = 1'b1; data_available = 1'b1; data_is_long = 1'b0; data_in = 16'h0055;
    #1 chk("busy same cycle as request", busy, 1);
    @(negedge clk);
    start_continue = 1'b0; data_available = 1'b0;
    #1 chk("busy cycle N+1", busy, 1);
    @(negedge clk); @(negedge clk);
    #1 chk("busy low by N+3", busy, 0);
    pulse_hmac_reset();

    // "abc": one block, length 24 bits.
    push_w(0, 32'h61626380);
    for (int i = 1; i < 15; i++) push_w(i, 32'h0);
    push_w(15, 32'h00000018);
    req(1, 1, 16'h6162);
    req(1, 0, 16'h0063);
    finalize(1);
    chk("abc writes consumed", exp_q.size(), 0);

    // Digest readout: halfword k is k+1, saturating at index 15.
    for (int k = 0; k < 19; k++) begin
      @(negedge clk); #1;
      chk("data_out", data_out, (k > 15) ? 16'h0010 : 16'(k + 1));
      start_continue = 1'b1; data_available = 1'b0;
      #1 chk("advance busy", busy, 1);
      @(negedge clk);
      start_continue = 1'b0;
      #1 chk("advance busy one cycle", busy, 0);
    end
    @(negedge clk);
    start_continue = 1'b1; data_available = 1'b1; data_in = 16'hFFFF;
    @(negedge clk);
    start_continue = 1'b0; data_available = 1'b0;
    #1 chk("data after finalize ignored: busy", busy, 0);
    chk("data after finalize ignored: data_out", data_out, 16'h0010);

    // 56 zero bytes: 0x80 spills into a second block.
    pulse_hmac_reset();
    for (int i = 0; i < 14; i++) push_w(i, 32'h0);
    push_w(14, 32'h80000000);
    push_w(15, 32'h0);
    for (int i = 0; i < 15; i++) push_w(i, 32'h0);
    push_w(15, 32'h000001C0);
    for (int i = 0; i < 28; i++) req(1, 1, 16'h0000);
    finalize(2);
    chk("two-block writes consumed", exp_q.size(), 0);

    // Hard reset while padding.
    pulse_hmac_reset();
    req(1, 0, 16'h0041);
    @(negedge clk);
    start_continue = 1'b1; data_available = 1'b0;
    @(negedge clk);
    start_continue = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("pad reset busy", busy, 0);
    chk("pad reset core_wr", core_wr, 0);
    chk("pad reset core_start", core_start, 0);
    chk("pad reset core_addr", core_addr, 0);
    chk("pad reset core_wdata", core_wdata, 0);
    chk("pad reset digest_sel", core_digest_sel, 0);
    s0 = starts;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("pad reset idle next cycle", busy, 0);
    repeat (100) @(negedge clk);
    #1 chk("no core_start after reset", starts - s0, 0);
    chk("pending writes", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
